// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Handshake and operand/result bundle between the execute stage and the
//   iterative multiply/divide unit.
//
//   master (execute stage / hazard unit side):
//     start, op[1:0], a[W-1:0], b[W-1:0], flush  -> driven
//     busy, done, hi[W-1:0], lo[W-1:0], div_by_zero <- observed
//   slave (muldiv_unit side): mirror image of master.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative W-bit multiply/divide unit for the execute stage. Signed and
//   unsigned multiply (radix-2 shift-add) and divide (restoring shift-subtract)
//   with architectural HI/LO result registers.
//
//   Sequence: IDLE -> PREP (magnitudes, result signs) -> RUN (W iterations)
//             -> FIX (sign correction, HI/LO write) -> DONE (done pulse).
//   flush returns any non-IDLE state to IDLE without touching HI/LO.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     bus  - muldiv_unit_if.slave: start/op/a/b/flush in,
//            busy/done/hi/lo/div_by_zero out
//   op encoding: 00 mult, 01 multu, 10 div, 11 divu.
//
//   Build option: define MULDIV_DIV_EN to build the divider. Without it,
//   divide ops go straight from IDLE to DONE, leave HI/LO untouched and
//   never raise div_by_zero.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } stateT;

  stateT state;
  stateT stateNext;

  // Latched request
  logic         opSigned;
  logic [W-1:0] aReg;
  logic [W-1:0] bReg;

  // Iteration datapath: {accHi, accLo} is the 2W product accumulator for
  // multiply, and {remainder, quotient} for divide. addend holds the
  // multiplicand magnitude or the divisor magnitude.
  logic [CW-1:0] cnt;
  logic [W-1:0]  accHi;
  logic [W-1:0]  accLo;
  logic [W-1:0]  addend;
  logic          negRes;

  // Architectural results
  logic [W-1:0] hiReg;
  logic [W-1:0] loReg;

  // Combinational helpers
  logic         accept;
  logic         busyC;
  logic         doneC;
  logic         negA;
  logic         negB;
  logic [W-1:0] magA;
  logic [W-1:0] magB;
  logic [W:0]   addSum;
  logic [W-1:0] stepHi;
  logic [W-1:0] stepLo;
  logic [2*W-1:0] prod;
  logic [W-1:0] fixHi;
  logic [W-1:0] fixLo;

`ifdef MULDIV_DIV_EN
  logic       opDiv;
  logic       negRem;
  logic       dbzReg;
  logic [W:0] trial;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    busyC     = 1'b0;
    doneC     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept = 1'b1;
`ifdef MULDIV_DIV_EN
          stateNext = PREP;
`else
          // No divider built: divide requests complete immediately.
          stateNext = bus.op[1] ? DONE : PREP;
`endif
        end
      end
      PREP: begin
        busyC     = 1'b1;
        stateNext = RUN;
      end
      RUN: begin
        busyC = 1'b1;
        if (cnt == '0) begin
          stateNext = FIX;
        end
      end
      FIX: begin
        busyC     = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        doneC     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Abort wins over any progress, including the FIX->DONE write.
    if (bus.flush && state != IDLE) begin
      stateNext = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath combinational logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Operand magnitudes; the most negative value maps onto its own unsigned
    // pattern, which is exactly its magnitude.
    negA = opSigned & aReg[W-1];
    negB = opSigned & bReg[W-1];
    magA = negA ? -aReg : aReg;
    magB = negB ? -bReg : bReg;

    // Multiply step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right by one (carry included).
    addSum = {1'b0, accHi} + {1'b0, addend & {W{accLo[0]}}};
    stepHi = addSum[W:1];
    stepLo = {addSum[0], accLo[W-1:1]};

`ifdef MULDIV_DIV_EN
    // Divide step: shift {rem, quo} left, try to subtract the divisor; a
    // borrow out of bit W means restore and shift in a 0 quotient bit.
    trial = {accHi, accLo[W-1]} - {1'b0, addend};
    if (opDiv) begin
      if (!trial[W]) begin
        stepHi = trial[W-1:0];
        stepLo = {accLo[W-2:0], 1'b1};
      end else begin
        stepHi = {accHi[W-2:0], accLo[W-1]};
        stepLo = {accLo[W-2:0], 1'b0};
      end
    end
`endif

    // Sign correction of the final result.
    prod  = negRes ? -{accHi, accLo} : {accHi, accLo};
    fixHi = prod[2*W-1:W];
    fixLo = prod[W-1:0];
`ifdef MULDIV_DIV_EN
    if (opDiv) begin
      if (bReg == '0) begin
        fixHi = aReg;
        fixLo = '1;
      end else begin
        fixHi = negRem ? -accHi : accHi;
        fixLo = negRes ? -accLo : accLo;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opSigned <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      cnt      <= '0;
      accHi    <= '0;
      accLo    <= '0;
      addend   <= '0;
      negRes   <= 1'b0;
      hiReg    <= '0;
      loReg    <= '0;
`ifdef MULDIV_DIV_EN
      opDiv    <= 1'b0;
      negRem   <= 1'b0;
      dbzReg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opSigned <= ~bus.op[0];
            aReg     <= bus.a;
            bReg     <= bus.b;
`ifdef MULDIV_DIV_EN
            opDiv    <= bus.op[1];
`endif
          end
        end
        PREP: begin
          cnt    <= CW'(W - 1);
          accHi  <= '0;
          negRes <= negA ^ negB;
`ifdef MULDIV_DIV_EN
          negRem <= negA;
          if (opDiv) begin
            accLo  <= magA;
            addend <= magB;
          end else begin
            accLo  <= magB;
            addend <= magA;
          end
`else
          accLo  <= magB;
          addend <= magA;
`endif
        end
        RUN: begin
          cnt   <= cnt - 1'b1;
          accHi <= stepHi;
          accLo <= stepLo;
        end
        FIX: begin
          if (!bus.flush) begin
            hiReg  <= fixHi;
            loReg  <= fixLo;
`ifdef MULDIV_DIV_EN
            dbzReg <= opDiv && (bReg == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy = busyC;
  assign bus.done = doneC;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;
`ifdef MULDIV_DIV_EN
  assign bus.div_by_zero = doneC & dbzReg;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed testbench for muldiv_unit at W=32. The edge on which start is
//   presented is edge 0; the unit samples it on edge 1 and raises done after
//   edge W+3 (35). Divide vectors run only when MULDIV_DIV_EN is defined;
//   otherwise the immediate-completion divide path is exercised instead.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  muldiv_unit_if #(.W(W)) bus ();

  muldiv_unit #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Results captured by runOp in the done cycle
  int         edgeN;
  logic       busyAtDone;
  logic       dbzAtDone;
  logic       busyGap;

  // Present one operation and wait (bounded) for done. Optionally pulse a
  // stray start with different operands after edge pulseEdge.
  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int pulseEdge);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    edgeN      = -1;
    busyAtDone = 1'bx;
    dbzAtDone  = 1'bx;
    busyGap    = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      bus.start = (e == pulseEdge);
      if (e == pulseEdge) begin
        bus.a = 100;
        bus.b = 100;
      end
      @(negedge clk);
      if (bus.done) begin
        edgeN      = e;
        busyAtDone = bus.busy;
        dbzAtDone  = bus.div_by_zero;
        break;
      end
      if (!bus.busy) busyGap = 1'b1;
    end
  endtask

  task automatic expectNoDone(input int n, input string name);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL %s: done pulses=%0d expected 0", name, seen);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000",
               {bus.busy, bus.done, bus.div_by_zero});
    end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      failures++;
      $display("FAIL reset_hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
    end
    rst = 1'b1;
  endtask

  task automatic test_multu;
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    checks++;
    if (edgeN != 35) begin
      failures++;
      $display("FAIL multu_latency: got %0d expected 35", edgeN);
    end
    checks++;
    if (busyAtDone !== 1'b0 || busyGap !== 1'b0) begin
      failures++;
      $display("FAIL multu_busy: busyAtDone=%b gap=%b expected 0/0", busyAtDone, busyGap);
    end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", bus.hi, bus.lo);
    end
    checks++;
    if (dbzAtDone !== 1'b0) begin
      failures++;
      $display("FAIL multu_dbz: got %b expected 0", dbzAtDone);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL multu_done_pulse: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_mult_signed;
    runOp(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    checks++;
    if (edgeN != 35 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      failures++;
      $display("FAIL mult_neg3x5: edge=%0d got %h_%h expected 35 ffffffff_fffffff1",
               edgeN, bus.hi, bus.lo);
    end
    runOp(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    checks++;
    if (edgeN != 35 || bus.hi !== 32'h4000_0000 || bus.lo !== 32'h0) begin
      failures++;
      $display("FAIL mult_minsq: edge=%0d got %h_%h expected 35 40000000_00000000",
               edgeN, bus.hi, bus.lo);
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_divide;
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    checks++;
    if (edgeN != 35 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_neg7_2: edge=%0d got hi=%h lo=%h expected 35 ffffffff fffffffd",
               edgeN, bus.hi, bus.lo);
    end
    runOp(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    checks++;
    if (edgeN != 35 || bus.lo !== 32'h7FFF_FFFC || bus.hi !== 32'h1) begin
      failures++;
      $display("FAIL divu_big_2: edge=%0d got hi=%h lo=%h expected 35 00000001 7ffffffc",
               edgeN, bus.hi, bus.lo);
    end
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || dbzAtDone !== 1'b0) begin
      failures++;
      $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b expected 00000000 80000000 0",
               bus.hi, bus.lo, dbzAtDone);
    end
  endtask

  task automatic test_div_by_zero;
    runOp(2'b11, 32'd100, 32'd0, 0);
    checks++;
    if (edgeN != 35 || dbzAtDone !== 1'b1) begin
      failures++;
      $display("FAIL dbz_flag: edge=%0d dbz=%b expected 35 1", edgeN, dbzAtDone);
    end
    checks++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h0000_0064) begin
      failures++;
      $display("FAIL dbz_result: got hi=%h lo=%h expected 00000064 ffffffff", bus.hi, bus.lo);
    end
    runOp(2'b11, 32'd100, 32'd7, 0);
    checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || dbzAtDone !== 1'b0) begin
      failures++;
      $display("FAIL divu_100_7: got hi=%h lo=%h dbz=%b expected 2 e 0",
               bus.hi, bus.lo, dbzAtDone);
    end
  endtask
`else
  task automatic test_div_disabled;
    // hi/lo left at 0/42 by the preceding multu 6x7.
    runOp(2'b11, 32'd9, 32'd3, 0);
    checks++;
    if (edgeN != 1 || busyAtDone !== 1'b0) begin
      failures++;
      $display("FAIL nodiv_latency: edge=%0d busy=%b expected 1 0", edgeN, busyAtDone);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd42 || dbzAtDone !== 1'b0) begin
      failures++;
      $display("FAIL nodiv_hold: got hi=%h lo=%h dbz=%b expected 0 2a 0",
               bus.hi, bus.lo, dbzAtDone);
    end
  endtask
`endif

  task automatic test_flush;
    // 0x22 * 0x80000001 = 0x11_00000022 sets up the prior hi/lo.
    runOp(2'b01, 32'h22, 32'h8000_0001, 0);
    checks++;
    if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      failures++;
      $display("FAIL flush_setup: got %h_%h expected 00000011_00000022", bus.hi, bus.lo);
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd7;
    bus.b     = 32'd9;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk); #1;
      bus.start = (e == 4 || e == 6);  // stray starts while busy
    end
    // RUN cycle 10 follows edge 11: abort here.
    bus.start = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL flush_abort: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    expectNoDone(45, "flush_no_done");
    checks++;
    if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      failures++;
      $display("FAIL flush_hold: got %h_%h expected 00000011_00000022", bus.hi, bus.lo);
    end
    // start and flush together in IDLE: flush wins
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_idle: busy=%b expected 0", bus.busy);
    end
    expectNoDone(40, "flush_start_no_done");
    runOp(2'b00, 32'hFFFF_FFFF, 32'd2, 0);
    checks++;
    if (edgeN != 35 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL flush_recover: edge=%0d got %h_%h expected 35 ffffffff_fffffffe",
               edgeN, bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back;
    // A stray start mid-run must neither disturb nor queue behind the op.
    runOp(2'b01, 32'd3, 32'd4, 10);
    checks++;
    if (edgeN != 35 || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
      failures++;
      $display("FAIL busy_start_ignored: edge=%0d got %h_%h expected 35 0_c",
               edgeN, bus.hi, bus.lo);
    end
    expectNoDone(40, "no_queueing");
  endtask

  task automatic test_async_reset;
    runOp(2'b01, 32'd5, 32'd5, 0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'hFFFF;
    bus.b     = 32'hFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    runOp(2'b01, 32'd6, 32'd7, 0);
    checks++;
    if (edgeN != 35 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      failures++;
      $display("FAIL post_reset_multu: edge=%0d got %h_%h expected 35 0_2a",
               edgeN, bus.hi, bus.lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
`ifdef MULDIV_DIV_EN
    test_divide();
    test_div_by_zero();
`endif
    test_flush();
    test_back_to_back();
    test_async_reset();
`ifndef MULDIV_DIV_EN
    test_div_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
